blink_decoder: RTL and testbench
================================

// Module: blink_decoder
// PURPOSE
//  Receive-side counterpart of the blinker output: samples an asynchronous blink waveform,
//  measures period (rising edge to rising edge) and high time, in clk cycles.
//  Presents each measurement on a valid/ready interface for firmware or a compare unit.
//  Sits on the input pins, feeding a register block or a pattern checker.
// PARAMETERS
//  CNT_W        16  width of period/high-time counters and outputs
//  SYNC_STAGES  2   flip-flops in the blink_in synchronizer (>=2)
// PORTS
//  clk          in   1      single system clock
//  rst_n        in   1      asynchronous, active-low reset
//  en           in   1      measurement enable; low forces IDLE
//  blink_in     in   1      asynchronous blink waveform
//  meas_valid   out  1      measurement available
//  meas_ready   in   1      consumer accepts measurement
//  period       out  CNT_W  cycles between last two rising edges
//  high_time    out  CNT_W  cycles from rising edge to following falling edge
//  overrun      out  1      sticky: measurement dropped because previous not consumed
//  timeout      out  1      one-cycle pulse: no edge for 2^CNT_W-1 cycles
//  clr_overrun  in   1      synchronous clear of overrun
// BEHAVIOUR
//  Reset: meas_valid=0, period=0, high_time=0, overrun=0, timeout=0, FSM=IDLE,
//    synchronizer and counters=0. Async assert, sync-released by design-level logic.
//  Sync: blink_in through SYNC_STAGES FFs -> s; s_d = s delayed 1 clk.
//    rise = s & ~s_d; fall = ~s & s_d.
//  cnt: set to 1 on a rise cycle, else +1; saturates at all-ones. hcnt: cycles since rise.
//  FSM states IDLE, HIGH, LOW:
//   IDLE: wait for rise -> HIGH (cnt=1, no capture; first edge only arms).
//   HIGH: fall -> LOW (latch hcnt into high_pend).
//     rise cannot occur in HIGH (needs fall first).
//   LOW: rise -> capture {period=cnt, high_time=high_pend} -> HIGH, cnt=1.
//   HIGH/LOW: cnt reaches all-ones with no edge -> IDLE, timeout=1 for that one cycle.
//   en=0 (any state): next state IDLE, counters cleared. Pending meas_valid/data held.
//  Capture/handshake:
//   - Capture with meas_valid=0: load outputs, meas_valid=1 next clk.
//   - Accept = meas_valid & meas_ready at a clk edge. meas_valid falls after accept
//     unless a capture occurs in the same cycle; then new data loads and meas_valid stays 1.
//   - Capture while meas_valid=1 & meas_ready=0: new data discarded, outputs unchanged,
//     overrun=1 (sticky).
//  clr_overrun=1 clears overrun next clk. A simultaneous overrun event wins (overrun stays 1).
//  Latency: meas_valid rises SYNC_STAGES clk edges after the edge that first samples
//    blink_in high (LOW state, no pending data).
//  Minimum measurable: period>=2, high_time>=1. A pulse shorter than a clk may be missed.
//    Missed pulses are not flagged.
//  Stable outputs: period/high_time change only on a capture that loads.
// TESTING
//  Square wave high 5 / low 3 clks, meas_ready=1 -> after arming, each meas: period=8, high_time=5, overrun=0.
//  Same wave, meas_ready=0 for 20 clks -> first meas held stable, overrun=1.
//    Then ready=1, one accept, clr_overrun -> overrun=0.
//  Accept and new capture in same cycle -> meas_valid stays 1, new period loaded, no overrun.
//  CNT_W=4, blink_in held 0 after arming -> timeout pulse once at cnt=15, FSM IDLE, no meas_valid.
//  rst_n low mid-high-phase -> all outputs 0 immediately; after release, first rise only arms.
//    Second rise gives the first measurement.
//  en low for 3 clks mid-period -> no measurement spanning the gap.
//    Next valid meas needs two rises after en=1.

Source files
------------

// File: rtl/blink_decoder.sv
// Blink waveform decoder: synchronizes an asynchronous blink input, measures its period and
// high time in clk cycles, and presents each measurement on a valid/ready interface.
module blink_decoder #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             blink_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overrun,
    output logic             timeout,
    input  logic             clr_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_dly_q;
    logic                   s;
    logic                   rise;
    logic                   fall;

    state_e                 state_q, state_d;
    logic                   capture;
    logic                   latch_high;
    logic                   timeout_d, timeout_q;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       high_pend_q, high_pend_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   load;
    logic                   drop;

    // NOTE: flops use non-blocking (<=) so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], blink_in};
            s_dly_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_dly_q;
    assign fall = ~s & s_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (rise) state_d = HIGH;
                HIGH: begin
                    if (fall)                   state_d = LOW;
                    else if (cnt_q == CNT_MAX)  state_d = IDLE;
                end
                LOW: begin
                    if (rise)                   state_d = HIGH;
                    else if (cnt_q == CNT_MAX)  state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        capture    = 1'b0;
        latch_high = 1'b0;
        timeout_d  = 1'b0;
        if (en) begin
            case (state_q)
                HIGH: begin
                    latch_high = fall;
                    timeout_d  = ~fall & (cnt_q == CNT_MAX);
                end
                LOW: begin
                    capture   = rise;
                    timeout_d = ~rise & (cnt_q == CNT_MAX);
                end
                default: ;
            endcase
        end
    end

    // cnt restarts at every rise, so while HIGH it also serves as the high-time count.
    always_comb begin
        cnt_d       = cnt_q;
        high_pend_d = high_pend_q;
        if (!en) begin
            cnt_d       = '0;
            high_pend_d = '0;
        end else begin
            if (rise)                  cnt_d = CNT_ONE;
            else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            if (latch_high)            high_pend_d = cnt_q;
        end
    end

    // A capture loads only when the output slot is free or being accepted this cycle.
    always_comb begin
        load         = capture & (~meas_valid_q | meas_ready);
        drop         = capture & meas_valid_q & ~meas_ready;
        period_d     = load ? cnt_q : period_q;
        high_time_d  = load ? high_pend_q : high_time_q;
        meas_valid_d = meas_valid_q;
        if (load)                           meas_valid_d = 1'b1;
        else if (meas_valid_q & meas_ready) meas_valid_d = 1'b0;
        overrun_d = overrun_q;
        if (drop)             overrun_d = 1'b1;
        else if (clr_overrun) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            high_pend_q  <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            high_pend_q  <= high_pend_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign period     = period_q;
    assign high_time  = high_time_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_blink_decoder.sv
// Scoreboard bench for blink_decoder: directed blink waveforms push expected measurements,
// a negedge monitor pops and compares them on every accepted measurement.
module tb_blink_decoder;

    localparam int CNT_W       = 4;
    localparam int SYNC_STAGES = 2;

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             en          = 1'b0;
    logic             blink_in    = 1'b0;
    logic             meas_ready  = 1'b0;
    logic             clr_overrun = 1'b0;
    logic             meas_valid;
    logic             overrun;
    logic             timeout;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high_time;
    } meas_t;

    meas_t exp_q[$];
    meas_t mon_exp;
    int    n_vec = 0;
    int    n_err = 0;
    int    last_h = 0;
    int    last_l = 0;
    int    to_cnt;
    int    to_at;

    blink_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .blink_in    (blink_in),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .period      (period),
        .high_time   (high_time),
        .overrun     (overrun),
        .timeout     (timeout),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One blink cycle: h clks high, l clks low; if exp, its rise captures the previous cycle.
    task automatic pulse(input int h, input int l, input bit exp);
        meas_t m;
        if (exp) begin
            m.period    = CNT_W'(last_h + last_l);
            m.high_time = CNT_W'(last_h);
            exp_q.push_back(m);
        end
        blink_in = 1'b1;
        repeat (h) tick();
        blink_in = 1'b0;
        repeat (l) tick();
        last_h = h;
        last_l = l;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        en          = 1'b0;
        blink_in    = 1'b0;
        meas_ready  = 1'b0;
        clr_overrun = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        last_h = 0;
        last_l = 0;
    endtask

    task automatic drain(input string name);
        meas_ready = 1'b1;
        blink_in   = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
        check({name, "_valid_low"}, meas_valid, 1'b0);
    endtask

    // Monitor: every accept (valid & ready at the coming edge) must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && meas_valid && meas_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_meas: got period=%0d high_time=%0d, required none (t=%0t)",
                             period, high_time, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("meas_period", period, mon_exp.period);
                    check("meas_high_time", high_time, mon_exp.high_time);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at t=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_valid", meas_valid, 1'b0);
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout", timeout, 1'b0);

        // Steady square waves and minimum-size pulses with a ready consumer
        do_reset();
        en = 1'b1;
        meas_ready = 1'b1;
        pulse(5, 3, 1'b0);
        pulse(5, 3, 1'b1);
        pulse(5, 3, 1'b1);
        pulse(1, 1, 1'b1);
        pulse(3, 7, 1'b1);
        pulse(1, 1, 1'b1);
        pulse(2, 2, 1'b1);
        check("sq_overrun", overrun, 1'b0);
        drain("sq");

        // Stalled consumer: first measurement held, later ones dropped, overrun sticky
        do_reset();
        en = 1'b1;
        meas_ready = 1'b0;
        pulse(5, 3, 1'b0);
        pulse(4, 4, 1'b1);
        pulse(2, 2, 1'b0);
        check("ovr_mid_period", period, 8);
        check("ovr_mid_high_time", high_time, 5);
        check("ovr_set", overrun, 1'b1);
        pulse(3, 3, 1'b0);
        repeat (4) tick();
        check("ovr_held_valid", meas_valid, 1'b1);
        check("ovr_held_period", period, 8);
        check("ovr_held_high_time", high_time, 5);
        check("ovr_held_overrun", overrun, 1'b1);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        tick();
        check("ovr_accept_valid", meas_valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_cleared", overrun, 1'b0);
        drain("ovr");

        // Accept and new capture on the same edge
        do_reset();
        en = 1'b1;
        meas_ready = 1'b0;
        pulse(5, 3, 1'b0);
        pulse(4, 4, 1'b1);
        exp_q.push_back('{period: CNT_W'(8), high_time: CNT_W'(4)});
        blink_in = 1'b1;
        tick();
        tick();
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        check("same_valid", meas_valid, 1'b1);
        check("same_high_time", high_time, 4);
        check("same_overrun", overrun, 1'b0);
        blink_in = 1'b0;
        repeat (5) tick();
        drain("same");

        // Timeout: armed, then held low until the counter saturates
        do_reset();
        en = 1'b1;
        meas_ready = 1'b1;
        to_cnt = 0;
        to_at  = 0;
        blink_in = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 3) blink_in = 1'b0;
            if (timeout) begin
                to_cnt++;
                to_at = k;
            end
        end
        check("to_pulses", to_cnt, 1);
        check("to_cycle", to_at, 18);
        check("to_no_valid", meas_valid, 1'b0);
        pulse(5, 3, 1'b0);
        pulse(5, 3, 1'b1);
        drain("to");

        // Asynchronous reset in the middle of a high phase
        do_reset();
        en = 1'b1;
        meas_ready = 1'b1;
        pulse(5, 3, 1'b0);
        pulse(5, 3, 1'b1);
        exp_q.push_back('{period: CNT_W'(8), high_time: CNT_W'(5)});
        blink_in = 1'b1;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", meas_valid, 1'b0);
        check("mid_rst_period", period, 0);
        check("mid_rst_high_time", high_time, 0);
        check("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_timeout", timeout, 1'b0);
        check("mid_rst_consumed", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        blink_in = 1'b0;
        repeat (4) tick();
        last_h = 4;
        last_l = 4;
        pulse(5, 3, 1'b1);
        pulse(2, 2, 1'b1);
        drain("mid_rst");

        // Enable dropped for three clocks mid-period
        do_reset();
        en = 1'b1;
        meas_ready = 1'b1;
        pulse(5, 3, 1'b0);
        pulse(5, 3, 1'b1);
        exp_q.push_back('{period: CNT_W'(8), high_time: CNT_W'(5)});
        blink_in = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        tick();
        blink_in = 1'b0;
        repeat (3) tick();
        pulse(5, 3, 1'b0);
        pulse(5, 3, 1'b1);
        drain("en_gap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
